uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arb_pkg.sv | 50 +++++
 rtl/uart_tx_arb_timer.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the serial-pin arbiter (uart_tx_arbiter).
// Optional macro UART_TX_ARB_COLLISION_EN enables collision reporting in the top.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_TAPE = 2'd1,
        OWN_MIDI = 2'd2,
        OWN_UART = 2'd3
    } owner_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int COLL_CNT_W = 8;

    // A timeout of 1 would give a zero-width counter; keep at least one bit.
    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    // Requester vectors are packed as {uart, midi, tape}.
    function automatic owner_t pick_owner(input logic [2:0] tog);
        if (tog[2])      return OWN_UART;
        else if (tog[1]) return OWN_MIDI;
        else if (tog[0]) return OWN_TAPE;
        else             return OWN_NONE;
    endfunction

    function automatic logic owner_line(input owner_t who, input logic [2:0] lines);
        case (who)
            OWN_TAPE: return lines[0];
            OWN_MIDI: return lines[1];
            OWN_UART: return lines[2];
            default:  return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] owner_mask(input owner_t who);
        case (who)
            OWN_TAPE: return 3'b001;
            OWN_MIDI: return 3'b010;
            OWN_UART: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_arb_timer.sv
// Idle timer for the arbiter: reloads to IDLE_TIMEOUT-1, counts down while
// the owner line rests at mark, holds otherwise, and flags zero.
module uart_tx_arb_timer
    import uart_tx_arb_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 84000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int TW = timer_width(IDLE_TIMEOUT);
    localparam logic [TW-1:0] RELOAD = TW'(IDLE_TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (dec && (count != '0)) begin
            count <= count - TW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one serial pin between tape, MIDI and UART requesters by toggle-grant.
// Define UART_TX_ARB_COLLISION_EN to get the collision pulse and counter.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 84000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tape_out,
    input  logic       midi_out,
    input  logic       uart_out,
    output logic       uart_tx,
    output logic [1:0] owner,
    output logic       busy,
    output logic       collision,
    output logic [7:0] collision_cnt
);

    logic [2:0] lines;
    logic [2:0] prev_lines;
    logic [2:0] tog;
    logic [2:0] own_mask;
    state_t     state;
    owner_t     owner_q;
    owner_t     grant_id;
    logic       own_line;
    logic       own_tog;
    logic       timer_zero;
    logic       release_now;
    logic       grant;
    logic       timer_load;
    logic       timer_dec;

    assign lines = {uart_out, midi_out, tape_out};
    assign tog   = lines ^ prev_lines;

    // Loading the live inputs during reset too keeps the first cycle toggle-free.
    always_ff @(posedge clk_sys) begin
        prev_lines <= lines;
    end

    always_comb begin
        own_mask    = owner_mask(owner_q);
        own_line    = owner_line(owner_q, lines);
        own_tog     = |(tog & own_mask);
        release_now = (state == OWNED) && timer_zero && own_line && !own_tog;
        grant       = ((state == IDLE) || release_now) && (|tog);
        grant_id    = pick_owner(tog);
        timer_load  = grant || ((state == OWNED) && own_tog);
        timer_dec   = (state == OWNED) && own_line && !own_tog && !release_now;
    end

    uart_tx_arb_timer #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_timer (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .load   (timer_load),
        .dec    (timer_dec),
        .zero   (timer_zero)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner_q <= OWN_NONE;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state   <= OWNED;
                        owner_q <= grant_id;
                        uart_tx <= owner_line(grant_id, lines);
                    end
                end
                OWNED: begin
                    // A toggle landing on the release cycle is a fresh grant.
                    if (grant) begin
                        owner_q <= grant_id;
                        uart_tx <= owner_line(grant_id, lines);
                    end else if (release_now) begin
                        state   <= IDLE;
                        owner_q <= OWN_NONE;
                        uart_tx <= 1'b1;
                    end else begin
                        uart_tx <= own_line;
                    end
                end
                default: begin
                    state   <= IDLE;
                    owner_q <= OWN_NONE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    assign owner = owner_q;
    assign busy  = (owner_q != OWN_NONE);

`ifdef UART_TX_ARB_COLLISION_EN
    logic coll_hit;

    assign coll_hit = (state == OWNED) && !release_now && (|(tog & ~own_mask));

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            collision     <= 1'b0;
            collision_cnt <= '0;
        end else begin
            collision <= coll_hit;
            if (coll_hit && (collision_cnt != {COLL_CNT_W{1'b1}})) begin
                collision_cnt <= collision_cnt + 8'd1;
            end
        end
    end
`else
    assign collision     = 1'b0;
    assign collision_cnt = '0;
`endif

endmodule
